// File: rtl/vc_arbiter_if.sv
// Link-side bundle between the VC FIFOs, the arbiter and the downstream demux.
// slave is the arbiter's view; master is the surrounding FIFOs/demux.
interface vc_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 6
);
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] data_in_vc0;
    logic [DATA_WIDTH-1:0] data_in_vc1;
    logic                  pause;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  valid_out;
    logic                  active_vc;

    modport master (
        output vc0_empty,
        output vc1_empty,
        output data_in_vc0,
        output data_in_vc1,
        output pause,
        input  pop_vc0,
        input  pop_vc1,
        input  dataout,
        input  valid_out,
        input  active_vc
    );

    modport slave (
        input  vc0_empty,
        input  vc1_empty,
        input  data_in_vc0,
        input  data_in_vc1,
        input  pause,
        output pop_vc0,
        output pop_vc1,
        output dataout,
        output valid_out,
        output active_vc
    );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted two-VC scheduler: VC0 has priority but yields one word to a waiting VC1
// after VC0_WEIGHT consecutive grants. Popped words are registered onto the link.
module vc_arbiter #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned VC0_WEIGHT = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input logic         clk,
    input logic         reset,
    vc_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StVc0, StVc1} state_e;

    localparam logic [CNT_WIDTH-1:0] WeightCnt = CNT_WIDTH'(VC0_WEIGHT);
    localparam logic [CNT_WIDTH-1:0] OneCnt    = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
    logic                  valid_q, valid_d;
    logic                  active_q, active_d;
    logic                  grant_vc0, grant_vc1;

    // Next-state and grant decode; pause freezes state and counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        if (!bus.pause) begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.vc0_empty) begin
                        grant_vc0 = 1'b1;
                        state_d   = StVc0;
                        cnt_d     = OneCnt;
                    end else if (!bus.vc1_empty) begin
                        grant_vc1 = 1'b1;
                        state_d   = StVc1;
                        cnt_d     = '0;
                    end
                end
                StVc0: begin
                    if (!bus.vc0_empty && (bus.vc1_empty || (cnt_q < WeightCnt))) begin
                        grant_vc0 = 1'b1;
                        // Saturate so a late-arriving VC1 is served immediately.
                        cnt_d     = (cnt_q < WeightCnt) ? cnt_q + OneCnt : cnt_q;
                    end else if (!bus.vc1_empty) begin
                        grant_vc1 = 1'b1;
                        state_d   = StVc1;
                        cnt_d     = '0;
                    end else begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end
                end
                StVc1: begin
                    if (!bus.vc0_empty) begin
                        grant_vc0 = 1'b1;
                        state_d   = StVc0;
                        cnt_d     = OneCnt;
                    end else if (!bus.vc1_empty) begin
                        grant_vc1 = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Link register inputs: a cycle without a grant drives an idle, zeroed link.
    always_comb begin
        dataout_d = '0;
        valid_d   = 1'b0;
        active_d  = active_q;
        if (grant_vc0) begin
            dataout_d = bus.data_in_vc0;
            valid_d   = 1'b1;
            active_d  = 1'b0;
        end else if (grant_vc1) begin
            dataout_d = bus.data_in_vc1;
            valid_d   = 1'b1;
            active_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    // Pops are gated by reset so no word is consumed while the arbiter is held.
    assign bus.pop_vc0   = grant_vc0 & ~reset;
    assign bus.pop_vc1   = grant_vc1 & ~reset;
    assign bus.dataout   = dataout_q;
    assign bus.valid_out = valid_q;
    assign bus.active_vc = active_q;

endmodule
